// File: rtl/tone_period_meter.sv
// tone_period_meter: deglitched rising-edge period meter averaging 2^AVG_LOG2 periods, with tone-absence timeout
module tone_period_meter #(
   parameter int COUNT_W        = 24,
   parameter int FILTER_CYCLES  = 4,
   parameter int AVG_LOG2       = 2,
   parameter int MIN_PERIOD     = 8,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               enable,
   input  logic               tone_in,
   output logic [COUNT_W-1:0] period_out,
   output logic               period_valid,
   output logic               tone_present
);
   localparam int FW = $clog2(FILTER_CYCLES + 1);
   localparam int AW = COUNT_W + AVG_LOG2;
   localparam int NW = AVG_LOG2 + 1;
   localparam logic [FW-1:0] F_LAST = FW'(FILTER_CYCLES - 1);
   localparam logic [NW-1:0] N_FULL = NW'(1 << AVG_LOG2);
   localparam logic [COUNT_W-1:0] MIN_P = COUNT_W'(MIN_PERIOD);
   localparam logic [COUNT_W-1:0] TO = COUNT_W'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;

   state_t state, state_nx;
   logic s1, s2, filt, filt_q, rise, keep, done, timeout;
   logic [FW-1:0] scnt;
   logic [COUNT_W-1:0] cnt;
   logic [AW-1:0] acc;
   logic [NW-1:0] nsamp;

   assign rise    = filt & ~filt_q;
   assign keep    = rise && state == MEASURE && cnt >= MIN_P;
   assign done    = nsamp == N_FULL;
   assign timeout = state == MEASURE && !rise && cnt == TO;

   always_comb begin
      state_nx = state;
      if (!enable) state_nx = IDLE;
      else if (state == IDLE) state_nx = ARM;
      else if (state == ARM && rise) state_nx = MEASURE;
      else if (timeout) state_nx = ARM;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state        <= IDLE;
         s1           <= 1'b0;
         s2           <= 1'b0;
         filt         <= 1'b0;
         filt_q       <= 1'b0;
         scnt         <= '0;
         cnt          <= '0;
         acc          <= '0;
         nsamp        <= '0;
         period_out   <= '0;
         period_valid <= 1'b0;
         tone_present <= 1'b0;
      end else begin
         state        <= state_nx;
         s1           <= tone_in;
         s2           <= s1;
         filt_q       <= filt;
         period_valid <= 1'b0;
         if (s2 == filt) scnt <= '0;
         else if (scnt == F_LAST) begin
            filt <= ~filt;
            scnt <= '0;
         end else scnt <= scnt + 1'b1;
         if (!enable || state == IDLE || timeout) begin
            cnt          <= '0;
            acc          <= '0;
            nsamp        <= '0;
            tone_present <= 1'b0;
         end else if (state == ARM) cnt <= rise ? COUNT_W'(1) : '0;
         else begin
            cnt <= rise ? COUNT_W'(1) : cnt + 1'b1;
            // an edge landing on the publish cycle seeds the next average
            if (done) begin
               period_out   <= COUNT_W'(acc >> AVG_LOG2);
               period_valid <= 1'b1;
               tone_present <= 1'b1;
               acc          <= keep ? AW'(cnt) : '0;
               nsamp        <= NW'(keep);
            end else if (keep) begin
               acc   <= acc + AW'(cnt);
               nsamp <= nsamp + 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_tone_period_meter.sv
// tb_tone_period_meter: table vectors, hand corner sequences and random periods against an edge-time model
`timescale 1ns/1ps
module tb_tone_period_meter;
   localparam int T    = 3000;
   localparam int MINP = 8;

   logic        clk = 1'b0;
   logic        resetn, enable, tone_in;
   logic [23:0] period_out;
   logic        period_valid, tone_present;

   tone_period_meter #(.TIMEOUT_CYCLES(T)) dut (
      .clk(clk), .resetn(resetn), .enable(enable), .tone_in(tone_in),
      .period_out(period_out), .period_valid(period_valid), .tone_present(tone_present)
   );

   always #5 clk = ~clk;

   typedef struct {int p0; int p1; int p2; int p3; bit g; int exp;} vec_t;
   vec_t tbl [7];

   int checks = 0, errors = 0;
   int cyc = 0, vcnt = 0, mark = 0, rc = 0;
   int vlast = 0, last_exp = 0;
   bit pv_prev = 1'b0;
   int meas = 0, last = 0, acc = 0, n = 0;
   int exp_q[$];

   always @(posedge clk) cyc++;

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (period_valid) begin
         vcnt++;
         vlast = int'(period_out);
         chk("no_double_valid", pv_prev, 0);
         chk("valid_expected", exp_q.size() > 0, 1);
         if (exp_q.size() > 0) chk("model_period", period_out, exp_q.pop_front());
      end
      pv_prev = period_valid;
   end

   task automatic model_clear();
      meas = 0;
      acc  = 0;
      n    = 0;
   endtask

   task automatic model_rise();
      int p;
      if (!meas) begin
         meas = 1;
         acc  = 0;
         n    = 0;
      end else begin
         p = cyc - last;
         if (p > T) begin
            acc = 0;
            n   = 0;
         end else if (p >= MINP) begin
            acc += p;
            n++;
            if (n == 4) begin
               exp_q.push_back(acc >> 2);
               last_exp = acc >> 2;
               acc = 0;
               n   = 0;
            end
         end
      end
      last = cyc;
   endtask

   task automatic tick(input int k);
      repeat (k) @(negedge clk);
   endtask

   task automatic tone(input int hi, input int lo, input bit g);
      tone_in = 1'b1;
      model_rise();
      if (g) begin
         tick(hi / 2); tone_in = 1'b0;
         tick(2);      tone_in = 1'b1;
         tick(hi - hi / 2 - 2); tone_in = 1'b0;
         tick(lo / 2); tone_in = 1'b1;
         tick(3);      tone_in = 1'b0;
         tick(lo - lo / 2 - 3);
      end else begin
         tick(hi); tone_in = 1'b0;
         tick(lo);
      end
   endtask

   task automatic sq(input int p, input bit g = 1'b0);
      tone(p / 2, p - p / 2, g);
   endtask

   function automatic int pick(input vec_t v, input int j);
      return j == 0 ? v.p0 : j == 1 ? v.p1 : j == 2 ? v.p2 : v.p3;
   endfunction

   task automatic chk_result(input string nm, input int exp);
      chk({nm, "_count"}, vcnt, mark + 1);
      chk({nm, "_period"}, period_out, exp);
      chk({nm, "_present"}, tone_present, 1);
      mark = vcnt;
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: cycle %0d exceeded budget", cyc);
      $fatal(1);
   end

   initial begin
      tbl[0] = '{400, 400, 400, 400, 1'b0, 400};
      tbl[1] = '{398, 402, 398, 402, 1'b0, 400};
      tbl[2] = '{401, 401, 401, 402, 1'b0, 401};
      tbl[3] = '{8, 8, 9, 9, 1'b0, 8};
      tbl[4] = '{400, 400, 400, 400, 1'b1, 400};
      tbl[5] = '{200, 200, 200, 200, 1'b0, 200};
      tbl[6] = '{400, 400, 400, 400, 1'b0, 400};
      tone_in = 1'b0;
      enable  = 1'b1;
      resetn  = 1'b0;
      tick(1);
      resetn = 1'b1;
      chk("reset_period", period_out, 0);
      chk("reset_valid", period_valid, 0);
      chk("reset_present", tone_present, 0);
      tick(20);
      for (int i = 0; i < 7; i++) begin
         for (int j = 0; j < 4; j++) begin
            sq(pick(tbl[i], j), tbl[i].g);
            if (i == 0 && j == 3) chk("arm_no_early_valid", vcnt, 0);
            if (i > 0 && j == 1) chk_result("tbl", tbl[i-1].exp);
         end
      end
      sq(400);
      sq(400);
      chk_result("tbl", tbl[6].exp);

      for (int k = 0; k < 8 && !(meas && n == 2); k++) sq(400);
      enable = 1'b0;
      model_clear();
      tick(1);
      chk("dis_present", tone_present, 0);
      chk("dis_period_hold", period_out, last_exp);
      tick(9);
      enable = 1'b1;
      tick(50);
      chk("reen_period_hold", period_out, last_exp);
      mark = vcnt;
      repeat (4) sq(400);
      chk("reen_no_early_valid", vcnt, mark);
      sq(400);
      chk_result("reen", 400);

      sq(400);
      sq(400);
      resetn = 1'b0;
      tick(1);
      resetn = 1'b1;
      model_clear();
      last_exp = 0;
      chk("mid_reset_period", period_out, 0);
      chk("mid_reset_valid", period_valid, 0);
      chk("mid_reset_present", tone_present, 0);
      tick(20);
      mark = vcnt;
      repeat (4) sq(400);
      chk("rst_no_early_valid", vcnt, mark);
      sq(400);
      chk_result("rst", 400);

      for (int k = 0; k < 32; k++) begin
         int p, hi;
         p  = $urandom_range(500, 8);
         hi = $urandom_range(p - 4, 4);
         tone(hi, p - hi, 1'b0);
      end

      repeat (5) sq(400);
      tone_in = 1'b1;
      model_rise();
      rc = cyc;
      tick(200);
      tone_in = 1'b0;
      tick(rc + T - cyc);
      chk("timeout_present_before", tone_present, 1);
      tick(8);
      chk("timeout_present_after", tone_present, 0);
      mark = vcnt;
      tick(50);
      chk("timeout_no_valid", vcnt, mark);
      repeat (5) sq(200);
      chk_result("restart", 200);

      tick(20);
      chk("expected_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/tone_period_meter.md
Name: tone_period_meter

Overview:
- Measures the period of a 1-bit tone, counted in clock cycles between filtered rising edges.
- The tone source is a piano_note output_pwm, or a comparator-sliced microphone signal.
- It is the receive end of the synthesizer's tone path, and feeds pitch comparison logic in the training system.
- Suppresses short glitches and PWM-carrier chatter, averages 2^AVG_LOG2 periods per result, and flags tone absence on timeout.

Parameters:
COUNT_W, 24, width of period counter and period_out
FILTER_CYCLES, 4, consecutive stable cycles required before the filtered level changes (>=1)
AVG_LOG2, 2, log2 of the number of periods averaged per result (0..4)
MIN_PERIOD, 8, captured periods below this are discarded as noise
TIMEOUT_CYCLES, 1000000, cycles without a rising edge before tone is declared absent (< 2^COUNT_W)

Ports:
clk  in  1  system clock
resetn  in  1  synchronous active-low reset
enable  in  1  measurement enable; low forces IDLE
tone_in  in  1  asynchronous tone input
period_out  out  COUNT_W  averaged period in clock cycles
period_valid  out  1  one-cycle pulse when period_out updates
tone_present  out  1  high while a tone is being measured successfully

Behaviour:
- Interface: one clock, clk; reset is resetn, synchronous and active-low. Every register is updated only on the rising edge of clk.
- Reset values: period_out=0, period_valid=0, tone_present=0, filtered level=0, all counters and the accumulator 0, state=IDLE.
- Synchroniser: 2-FF chain on tone_in, reset to 0.
- Glitch filter:
  - The stability counter counts consecutive cycles where the synchronised input differs from the filtered level.
  - The filtered level toggles when the count reaches FILTER_CYCLES.
  - The counter clears whenever the input equals the filtered level.
- Edge detector: edge is high for one cycle on a 0->1 transition of the filtered level. Total latency from a tone_in rise to edge is 2 + FILTER_CYCLES cycles (+1 for registering).
- Period counter cnt:
  - On an edge cycle: sample=cnt, then cnt<=1.
  - Otherwise: cnt<=cnt+1.
  - Result: sample equals the exact cycle distance between consecutive edges.
- FSM states:
  - IDLE: cnt, accumulator and sample count held at 0; tone_present=0. Moves to ARM when enable=1.
  - ARM: waits for the first edge; no sample is taken. On edge, moves to MEASURE with cnt<=1.
  - MEASURE:
    - On each edge with sample>=MIN_PERIOD: acc+=sample and nsamp+=1.
    - On an edge with sample<MIN_PERIOD: sample is dropped and cnt is still restarted.
    - When nsamp reaches 2^AVG_LOG2, the next cycle sets period_out<=acc_total>>AVG_LOG2, period_valid=1 for one cycle and tone_present<=1. acc and nsamp clear in that same cycle.
    - acc_total includes the sample accepted in the completing cycle.
  - Timeout: in MEASURE, when cnt reaches TIMEOUT_CYCLES with no edge, go to ARM and clear acc/nsamp/tone_present. No period_valid is issued.
- Accumulator width is COUNT_W+AVG_LOG2, so it cannot overflow. The quotient is truncated.
- enable=0 in any state: next cycle goes to IDLE and clears acc, nsamp, cnt and tone_present. period_out holds its last value.
- The filter and synchroniser keep running regardless of enable.
- Simultaneous edge and timeout in the same cycle: the edge wins, the sample is accepted and no timeout occurs.
- resetn=0 mid-measurement: all state returns to reset values on the next clock; partial averages are discarded.
- period_valid is never asserted for two consecutive cycles.

Test Plan:
- Setup: clk period 10 ns, defaults, enable=1, resetn pulsed low for 1 cycle.
- 50% square, period 400 cycles -> first period_valid after the 5th rising edge (1 arm + 4 samples). period_out=400, tone_present=1; repeats every 4 periods with 400.
- Periods alternating 398/402 -> period_out=400. Periods 401,401,401,402 -> period_out=401 (1605>>2, truncated).
- Period-400 tone with a 2-cycle low glitch inside each high phase and 3-cycle high chatter inside low phases (FILTER_CYCLES=4) -> glitches are ignored and period_out=400.
- Tone stopped after valid results -> tone_present falls exactly TIMEOUT_CYCLES cycles after the last edge (+ pipeline); no period_valid. A restarted tone with period 200 -> next result is 200 after 5 edges.
- enable dropped after 2 samples, re-raised 10 cycles later -> state goes IDLE then ARM. The next result averages only post-enable periods; period_out holds 400 throughout.
- resetn low for 1 cycle mid-average -> all outputs 0 the next cycle. The measurement restarts; the first valid appears after 5 new edges.
